swd_memap_seq: RTL

Memory-access sequencer that sits directly upstream of `swd_if` in the AHB3-lite remote bridge. It accepts single 8/16/32-bit memory read/write requests from the bus-side front end and expands each into the ordered DP/AP register transactions on the `swd_if` register interface: SELECT, CSW, TAR, DRW and RDBUFF. It performs byte-lane steering, catches misaligned requests, and propagates `swd_if` error codes back as a per-request response.

---
 rtl/swd_memap_seq_if.sv | 24 ++
 rtl/swd_memap_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/swd_memap_seq_if.sv
// swd_memap_seq_if: request/response bundle and swd_if register-command signals
// of the MEM-AP sequencer; slave is the sequencer, master is its environment.
interface swd_memap_seq_if;
  logic        REQ_VALID, REQ_READY, REQ_WRITE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [2:0]  RSP_ERR;
  logic        SWD_APnDP, SWD_WRITE, SWD_VALID, SWD_READY, SWD_CLR;
  logic [1:0]  SWD_ADDR;
  logic [31:0] SWD_DATI, SWD_DATO;
  logic [2:0]  SWD_ERR;
  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_SIZE, REQ_WDATA, SWD_READY, SWD_DATO, SWD_ERR,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, SWD_APnDP, SWD_ADDR, SWD_DATI, SWD_WRITE,
           SWD_VALID, SWD_CLR
  );
  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_SIZE, REQ_WDATA, SWD_READY, SWD_DATO, SWD_ERR,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, SWD_APnDP, SWD_ADDR, SWD_DATI, SWD_WRITE,
           SWD_VALID, SWD_CLR
  );
endinterface

// File: rtl/swd_memap_seq.sv
// swd_memap_seq: expands 8/16/32-bit memory requests into SELECT/CSW/TAR/DRW/RDBUFF swd_if steps.
// Define SWD_MEMAP_CACHE_EN to skip SELECT/CSW/TAR writes whose value is already in the target.
module swd_memap_seq #(
  parameter logic [7:0]  AP_SEL   = 8'h00,
  parameter logic [31:0] CSW_BASE = 32'h2300_0000
) (
  input logic CLK,
  input logic RESET,
  swd_memap_seq_if.slave bus
);
  typedef enum logic [3:0] {IDLE, CHECK, SEL, CSW, TAR, DRW, RDBUF, RESP, ERRCLR} state_t;
  typedef enum logic [1:0] {ISSUE, WLOW, WHIGH} phase_t;
  state_t state_q, state_d, first, after_sel, after_csw, after_step;
  phase_t phase_q, phase_d;
  logic        wr_q, wr_d, apndp_q, apndp_d, write_q, write_d;
  logic [1:0]  size_q, size_d, swd_addr_q, swd_addr_d;
  logic [2:0]  err_q, err_d, rsp_err_q;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, dati_q, dati_d, rsp_rdata_q;
  logic [31:0] csw_val, rd_ext;
  logic        req_ready_q, rsp_valid_q, swd_valid_q, swd_clr_q;
  logic        step, done, bad, skip_sel, skip_csw, skip_tar;
  assign csw_val = CSW_BASE | {30'h0, size_q};
  assign step = state_q inside {SEL, CSW, TAR, DRW, RDBUF};
  assign done = step && phase_q == WHIGH && bus.SWD_READY;
  assign bad = size_q == 2'd3 || (size_q == 2'd1 && addr_q[0]) || (size_q == 2'd2 && addr_q[1:0] != 2'b00);
  assign rd_ext = size_q == 2'd0 ? {24'h0, bus.SWD_DATO[{addr_q[1:0], 3'b000} +: 8]} :
                  size_q == 2'd1 ? {16'h0, addr_q[1] ? bus.SWD_DATO[31:16] : bus.SWD_DATO[15:0]} :
                  bus.SWD_DATO;
`ifdef SWD_MEMAP_CACHE_EN
  logic        sel_v_q, csw_v_q, tar_v_q;
  logic [31:0] csw_c_q, tar_c_q;
  assign skip_sel = sel_v_q;
  assign skip_csw = csw_v_q && csw_c_q == csw_val;
  assign skip_tar = tar_v_q && tar_c_q == addr_q;
  // Only writes that completed cleanly are remembered; any error forgets everything.
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sel_v_q <= 1'b0;
      csw_v_q <= 1'b0;
      tar_v_q <= 1'b0;
      csw_c_q <= 32'h0;
      tar_c_q <= 32'h0;
    end else if (state_q == ERRCLR || (state_q == CHECK && bad)) begin
      sel_v_q <= 1'b0;
      csw_v_q <= 1'b0;
      tar_v_q <= 1'b0;
    end else if (done && bus.SWD_ERR == 3'd0) begin
      if (state_q == SEL) sel_v_q <= 1'b1;
      if (state_q == CSW) begin
        csw_v_q <= 1'b1;
        csw_c_q <= csw_val;
      end
      if (state_q == TAR) begin
        tar_v_q <= 1'b1;
        tar_c_q <= addr_q;
      end
    end
`else
  assign skip_sel = 1'b0;
  assign skip_csw = 1'b0;
  assign skip_tar = 1'b0;
`endif
  assign after_csw = skip_tar ? DRW : TAR;
  assign after_sel = skip_csw ? after_csw : CSW;
  assign first = skip_sel ? after_sel : SEL;
  assign after_step = bus.SWD_ERR != 3'd0 ? ERRCLR :
                      state_q == SEL ? after_sel :
                      state_q == CSW ? after_csw :
                      state_q == TAR ? DRW :
                      state_q == DRW && !wr_q ? RDBUF : RESP;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wr_d = wr_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata_d = rdata_q;
    apndp_d = apndp_q;
    swd_addr_d = swd_addr_q;
    dati_d = dati_q;
    write_d = write_q;
    case (state_q)
      IDLE: if (req_ready_q && bus.REQ_VALID) begin
        state_d = CHECK;
        wr_d = bus.REQ_WRITE;
        size_d = bus.REQ_SIZE;
        addr_d = bus.REQ_ADDR;
        wdata_d = bus.REQ_SIZE == 2'd0 ? {4{bus.REQ_WDATA[7:0]}} :
                  bus.REQ_SIZE == 2'd1 ? {2{bus.REQ_WDATA[15:0]}} : bus.REQ_WDATA;
        err_d = 3'd0;
        rdata_d = 32'h0;
      end
      CHECK: begin
        state_d = bad ? RESP : first;
        err_d = bad ? 3'd6 : 3'd0;
      end
      RESP: state_d = IDLE;
      ERRCLR: state_d = RESP;
      default: begin
        phase_d = phase_q == ISSUE && bus.SWD_READY ? WLOW :
                  phase_q == WLOW && !bus.SWD_READY ? WHIGH :
                  done ? ISSUE : phase_q;
        if (done) begin
          state_d = after_step;
          err_d = bus.SWD_ERR;
          rdata_d = state_q == RDBUF ? rd_ext : rdata_q;
        end
      end
    endcase
    // Command fields load on entry to a step and stay put until its last phase ends.
    if (state_d inside {SEL, CSW, TAR, DRW, RDBUF}) begin
      apndp_d = !(state_d inside {SEL, RDBUF});
      swd_addr_d = state_d == SEL ? 2'd2 : state_d == CSW ? 2'd0 : state_d == TAR ? 2'd1 : 2'd3;
      dati_d = state_d == SEL ? {AP_SEL, 24'h0} : state_d == CSW ? csw_val :
               state_d == TAR ? addr_q : state_d == DRW && wr_q ? wdata_q : 32'h0;
      write_d = state_d inside {SEL, CSW, TAR} || (state_d == DRW && wr_q);
    end
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      phase_q <= ISSUE;
      wr_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      err_q <= 3'd0;
      rdata_q <= 32'h0;
      apndp_q <= 1'b0;
      swd_addr_q <= 2'd0;
      dati_q <= 32'h0;
      write_q <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 3'd0;
      rsp_rdata_q <= 32'h0;
      swd_valid_q <= 1'b0;
      swd_clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wr_q <= wr_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      apndp_q <= apndp_d;
      swd_addr_q <= swd_addr_d;
      dati_q <= dati_d;
      write_q <= write_d;
      req_ready_q <= state_d == IDLE;
      rsp_valid_q <= state_d == RESP;
      rsp_err_q <= state_d == RESP ? err_d : 3'd0;
      rsp_rdata_q <= state_d == RESP && !wr_d && err_d == 3'd0 ? rdata_d : 32'h0;
      swd_valid_q <= step && phase_q == ISSUE && bus.SWD_READY;
      swd_clr_q <= state_d == ERRCLR;
    end
  assign bus.REQ_READY = req_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR = rsp_err_q;
  assign bus.SWD_APnDP = apndp_q;
  assign bus.SWD_ADDR = swd_addr_q;
  assign bus.SWD_DATI = dati_q;
  assign bus.SWD_WRITE = write_q;
  assign bus.SWD_VALID = swd_valid_q;
  assign bus.SWD_CLR = swd_clr_q;
endmodule
